// File: rtl/phy_rx_deser.sv
// phy_rx_deser: two-lane serial receiver. Each lane hunts for the comma
// byte, confirms byte alignment over LOCK_CNT commas, then delivers bytes.
// Once both lanes are locked, lane bytes are unstriped onto data_out.
// Order is lane 0, then lane 1 four cycles later.

module phy_rx_deser_lane #(
  parameter logic [7:0] COMMA    = 8'hBC,
  parameter int         LOCK_CNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       rx_in,
  output logic       sync,
  output logic       strobe,
  output logic [7:0] hold_byte,
  output logic       hold_valid
);

  localparam int CW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} lane_state_e;

  lane_state_e state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d;
  logic          strobe_q, strobe_d;
  logic [7:0]    hold_byte_q, hold_byte_d;
  logic          hold_valid_q, hold_valid_d;
  logic          sync_q, sync_d;

  // Lane state register; reset drops any partial byte and forces a fresh lock.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state_q      <= SEARCH;
      shreg_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      comma_cnt_q  <= '0;
      strobe_q     <= 1'b0;
      hold_byte_q  <= 8'h00;
      hold_valid_q <= 1'b0;
      sync_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      comma_cnt_q  <= comma_cnt_d;
      strobe_q     <= strobe_d;
      hold_byte_q  <= hold_byte_d;
      hold_valid_q <= hold_valid_d;
      sync_q       <= sync_d;
    end
  end

  // Alignment FSM: compare the freshly shifted byte against COMMA at boundaries.
  always_comb begin
    shreg_d      = {shreg_q[6:0], rx_in};
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    comma_cnt_d  = comma_cnt_q;
    strobe_d     = 1'b0;
    hold_byte_d  = hold_byte_q;
    hold_valid_d = hold_valid_q;
    case (state_q)
      SEARCH: begin
        if (shreg_d == COMMA) begin
          state_d     = ALIGN;
          bit_cnt_d   = 3'd0;
          comma_cnt_d = CW'(1);
        end
      end
      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_d == 3'd0) begin
          if (shreg_d == COMMA) begin
            comma_cnt_d = comma_cnt_q + CW'(1);
            if (comma_cnt_d == CW'(LOCK_CNT)) begin
              state_d = LOCKED;
            end
          end else begin
            state_d     = SEARCH;
            comma_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_d == 3'd0) begin
          strobe_d     = 1'b1;
          hold_byte_d  = shreg_d;
          hold_valid_d = (shreg_d != COMMA);
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
    sync_d = (state_d == LOCKED);
  end

  assign sync       = sync_q;
  assign strobe     = strobe_q;
  assign hold_byte  = hold_byte_q;
  assign hold_valid = hold_valid_q;

endmodule

module phy_rx_deser #(
  parameter logic [7:0] COMMA    = 8'hBC,
  parameter int         LOCK_CNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       rx_in_0,
  input  logic       rx_in_1,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       sync_0,
  output logic       sync_1,
  output logic       active_out
);

  logic       strobe_0, strobe_1;
  logic [7:0] hold_byte_0, hold_byte_1;
  logic       hold_valid_0, hold_valid_1;

  logic       active_q, active_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic [2:0] pend_q, pend_d;

  phy_rx_deser_lane #(.COMMA(COMMA), .LOCK_CNT(LOCK_CNT)) u_lane_0 (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .rx_in      (rx_in_0),
    .sync       (sync_0),
    .strobe     (strobe_0),
    .hold_byte  (hold_byte_0),
    .hold_valid (hold_valid_0)
  );

  phy_rx_deser_lane #(.COMMA(COMMA), .LOCK_CNT(LOCK_CNT)) u_lane_1 (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .rx_in      (rx_in_1),
    .sync       (sync_1),
    .strobe     (strobe_1),
    .hold_byte  (hold_byte_1),
    .hold_valid (hold_valid_1)
  );

  // Unstriper registers: link-active flag, output byte/valid, lane-1 slot timer.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      active_q <= 1'b0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      pend_q   <= 3'd0;
    end else begin
      active_q <= active_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      pend_q   <= pend_d;
    end
  end

  // Lane 0 emits the cycle after its strobe; lane 1 follows four cycles later
  // unless a new lane-0 strobe restarts the pair first.
  always_comb begin
    active_d = sync_0 & sync_1;
    data_d   = data_q;
    valid_d  = 1'b0;
    pend_d   = pend_q;
    if (!active_q) begin
      pend_d = 3'd0;
    end else if (strobe_0) begin
      data_d  = hold_byte_0;
      valid_d = hold_valid_0;
      pend_d  = 3'd1;
    end else if (pend_q == 3'd4) begin
      data_d  = hold_byte_1;
      valid_d = hold_valid_1;
      pend_d  = 3'd0;
    end else if (pend_q != 3'd0) begin
      pend_d = pend_q + 3'd1;
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign active_out = active_q;

  // strobe_1 is not needed: lane-1 bytes are taken from its hold register.
  logic unused_strobe_1;
  assign unused_strobe_1 = strobe_1;

endmodule
